// File: rtl/word_length_pkg.sv
// Shared types and constants for the word length pipeline: code enum and code-to-length map.
// Used by word_length_classify and word_length_pipe (optional stats via WORD_LENGTH_STATS_EN).
package word_length_pkg;

  typedef enum logic [2:0] {
    ZZZZ = 3'b000,
    MMMM = 3'b001,
    ZZZX = 3'b010,
    MMMX = 3'b011,
    MMXX = 3'b100,
    XXXX = 3'b101
  } code_e;

  localparam logic [2:0] CODE_IDLE = 3'b111;

  localparam logic [5:0] LEN_ZZZZ = 6'd2;
  localparam logic [5:0] LEN_MMMM = 6'd6;
  localparam logic [5:0] LEN_ZZZX = 6'd12;
  localparam logic [5:0] LEN_MMMX = 6'd16;
  localparam logic [5:0] LEN_MMXX = 6'd24;
  localparam logic [5:0] LEN_XXXX = 6'd34;

  // Unused codes 110/111 report zero length.
  function automatic logic [5:0] code_len(input logic [2:0] code);
    logic [5:0] len;
    case (code)
      ZZZZ:    len = LEN_ZZZZ;
      MMMM:    len = LEN_MMMM;
      ZZZX:    len = LEN_ZZZX;
      MMMX:    len = LEN_MMMX;
      MMXX:    len = LEN_MMXX;
      XXXX:    len = LEN_XXXX;
      default: len = 6'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/word_length_classify.sv
// Combinational priority encoder: zzzz > mmmm > zzzx > mmmx > mmxx > xxxx.
module word_length_classify
  import word_length_pkg::*;
(
  input  logic       zero,
  input  logic       zero3,
  input  logic       match,
  input  logic [1:0] match_type,
  output code_e      code
);

  always_comb begin
    code = XXXX;
    if (zero)                             code = ZZZZ;
    else if (match && match_type == 2'b11) code = MMMM;
    else if (zero3)                        code = ZZZX;
    else if (match && match_type == 2'b10) code = MMMX;
    else if (match && match_type == 2'b01) code = MMXX;
  end

endmodule

// File: rtl/word_length_pipe.sv
// Two-stage word classifier with per-block bit accounting and valid/ready flow control.
// Define WORD_LENGTH_STATS_EN to add per-code occurrence counters for the last completed block.
module word_length_pipe
  import word_length_pkg::*;
#(
  parameter  int BLOCK_WORDS = 64,
  parameter  int LEN_W       = 6,
  localparam int SUM_W       = $clog2(BLOCK_WORDS*34+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_zero,
  input  logic             i_zero3,
  input  logic             i_match,
  input  logic [1:0]       i_match_type,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [2:0]       o_code,
  output logic [LEN_W-1:0] o_length,
  output logic             o_block_last,
  output logic [SUM_W-1:0] o_block_bits
`ifdef WORD_LENGTH_STATS_EN
  ,
  input  logic [2:0]       i_stat_sel,
  output logic [SUM_W-1:0] o_stat_count
`endif
);

  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  code_e            in_code;
  logic             s1_valid;
  logic [2:0]       s1_code;
  logic             s1_last;
  logic             s1_load;
  logic             s2_load;
  logic [CNT_W-1:0] word_cnt;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_next;
  logic             closes;

  word_length_classify u_classify (
    .zero       (i_zero),
    .zero3      (i_zero3),
    .match      (i_match),
    .match_type (i_match_type),
    .code       (in_code)
  );

  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_valid || s2_load;
  assign o_ready = s1_load && !i_reset;

  // Block accounting is resolved as the word enters S2, so the accumulator is
  // already clear when the closing word is presented and the next word follows at once.
  assign acc_next = acc + SUM_W'(code_len(s1_code));
  assign closes   = s1_last || (word_cnt == CNT_W'(BLOCK_WORDS-1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_code  <= CODE_IDLE;
      s1_last  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_code <= in_code;
        s1_last <= i_last;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid      <= 1'b0;
      o_code       <= CODE_IDLE;
      o_length     <= '0;
      o_block_last <= 1'b0;
      o_block_bits <= '0;
      acc          <= '0;
      word_cnt     <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_code       <= s1_code;
        o_length     <= LEN_W'(code_len(s1_code));
        o_block_last <= closes;
        o_block_bits <= closes ? acc_next : '0;
        if (closes) begin
          acc      <= '0;
          word_cnt <= '0;
        end else begin
          acc      <= acc_next;
          word_cnt <= word_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef WORD_LENGTH_STATS_EN
  logic [SUM_W-1:0] run_cnt [8];
  logic [SUM_W-1:0] blk_cnt [8];

  // Counts follow words as they leave the pipe; the snapshot includes the closing word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < 8; c++) begin
        run_cnt[c] <= '0;
        blk_cnt[c] <= '0;
      end
    end else if (o_valid && i_ready) begin
      for (int c = 0; c < 8; c++) begin
        if (o_block_last) begin
          blk_cnt[c] <= run_cnt[c] + SUM_W'(o_code == 3'(c));
          run_cnt[c] <= '0;
        end else if (o_code == 3'(c)) begin
          run_cnt[c] <= run_cnt[c] + SUM_W'(1);
        end
      end
    end
  end

  assign o_stat_count = blk_cnt[i_stat_sel];
`endif

endmodule
